// File: rtl/rpsc_pkg.sv
// Shared types and cycle constants for the RPSC card 1 startup sequencer.
package rpsc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_FAN_SPINUP   = 3'd1,
        ST_CA_WAIT_PERM = 3'd2,
        ST_CA_WAIT_OK   = 3'd3,
        ST_RUN          = 3'd4,
        ST_SHUTDOWN     = 3'd5,
        ST_FAULT        = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_ALARM      = 3'd1,
        FC_FAN        = 3'd2,
        FC_PERM       = 3'd3,
        FC_CA_TIMEOUT = 3'd4,
        FC_CA_LOST    = 3'd5
    } fault_code_t;

    localparam int CNT_W = 26;

    // Production dwells at 781.25 kHz, and the short counts used in simulation.
    localparam int unsigned FAN_SPINUP_CYC    = 2343750;
    localparam int unsigned PERM_TIMEOUT_CYC  = 781250;
    localparam int unsigned CA_OK_TIMEOUT_CYC = 50000000;
    localparam int unsigned FAN_RUNDOWN_CYC   = 7812500;

    localparam int unsigned TEST_FAN_SPINUP_CYC    = 8;
    localparam int unsigned TEST_PERM_TIMEOUT_CYC  = 16;
    localparam int unsigned TEST_CA_OK_TIMEOUT_CYC = 40;
    localparam int unsigned TEST_FAN_RUNDOWN_CYC   = 8;

    function automatic logic expired(input logic [CNT_W-1:0] cnt, input int unsigned cyc);
        return cnt == CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/rpsc_sync2.sv
// Two-flop synchronizer with a per-bit reset value, so active-low inputs reset inactive.
module rpsc_sync2 #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: flops use non-blocking assignments so meta and q shift as one pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rpsc_startup_sequencer.sv
// Startup/shutdown sequencer for RPSC card 1: fan first, then CA supply, with fault latching.
// Optional build macro RPSC_SEQ_AUTORESTART_EN enables one automatic retry after a non-alarm fault.
module rpsc_startup_sequencer
    import rpsc_pkg::*;
#(
    parameter bit test_mode = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       fault_ack,
    input  logic       not_alarm,
    input  logic       fan_on_perm_n,
    input  logic       ca_on_perm_n,
    input  logic       not_ca_ok,
    output logic       fan_act,
    output logic       ca_ps_act,
    output logic       running,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] state_o
);

    localparam int unsigned SPINUP_CYC  = test_mode ? TEST_FAN_SPINUP_CYC    : FAN_SPINUP_CYC;
    localparam int unsigned PERM_CYC    = test_mode ? TEST_PERM_TIMEOUT_CYC  : PERM_TIMEOUT_CYC;
    localparam int unsigned CA_OK_CYC   = test_mode ? TEST_CA_OK_TIMEOUT_CYC : CA_OK_TIMEOUT_CYC;
    localparam int unsigned RUNDOWN_CYC = test_mode ? TEST_FAN_RUNDOWN_CYC   : FAN_RUNDOWN_CYC;

    logic        not_alarm_s, fan_on_perm_n_s, ca_on_perm_n_s, not_ca_ok_s;
    state_t      state, next_state;
    fault_code_t code_q, next_code, cause;
    logic        go_fault;
    logic [CNT_W-1:0] cnt;

    // All four card returns are active-low, so they reset to their inactive level.
    rpsc_sync2 #(.WIDTH(4), .RST_VAL(4'b1111)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({not_alarm, fan_on_perm_n, ca_on_perm_n, not_ca_ok}),
        .q     ({not_alarm_s, fan_on_perm_n_s, ca_on_perm_n_s, not_ca_ok_s})
    );

`ifdef RPSC_SEQ_AUTORESTART_EN
    logic retry_q, set_retry, clr_retry;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        next_state = state;
        next_code  = code_q;
        cause      = FC_NONE;
        go_fault   = 1'b0;
`ifdef RPSC_SEQ_AUTORESTART_EN
        set_retry  = 1'b0;
        clr_retry  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (!not_alarm_s) begin
                        go_fault = 1'b1;
                        cause    = FC_ALARM;
                    end else begin
                        next_state = ST_FAN_SPINUP;
                    end
                end
            end
            ST_FAN_SPINUP, ST_CA_WAIT_PERM, ST_CA_WAIT_OK, ST_RUN: begin
                if (!not_alarm_s) begin
                    go_fault = 1'b1;
                    cause    = FC_ALARM;
                end else if (stop) begin
                    next_state = ST_SHUTDOWN;
                end else begin
                    case (state)
                        ST_FAN_SPINUP: if (expired(cnt, SPINUP_CYC)) begin
                            if (!fan_on_perm_n_s) next_state = ST_CA_WAIT_PERM;
                            else begin go_fault = 1'b1; cause = FC_FAN; end
                        end
                        ST_CA_WAIT_PERM: begin
                            if (!ca_on_perm_n_s) next_state = ST_CA_WAIT_OK;
                            else if (expired(cnt, PERM_CYC)) begin go_fault = 1'b1; cause = FC_PERM; end
                        end
                        ST_CA_WAIT_OK: begin
                            if (!not_ca_ok_s) next_state = ST_RUN;
                            else if (expired(cnt, CA_OK_CYC)) begin go_fault = 1'b1; cause = FC_CA_TIMEOUT; end
                        end
                        default: begin
                            if (not_ca_ok_s || ca_on_perm_n_s) begin go_fault = 1'b1; cause = FC_CA_LOST; end
                        end
                    endcase
                end
            end
            ST_SHUTDOWN: begin
                if (!not_alarm_s) begin
                    go_fault = 1'b1;
                    cause    = FC_ALARM;
                end else if (expired(cnt, RUNDOWN_CYC)) begin
`ifdef RPSC_SEQ_AUTORESTART_EN
                    next_state = (retry_q && start && !stop) ? ST_FAN_SPINUP : ST_IDLE;
`else
                    next_state = ST_IDLE;
`endif
                end
            end
            ST_FAULT: begin
                if (fault_ack && not_alarm_s) begin
                    next_state = ST_SHUTDOWN;
                    next_code  = FC_NONE;
`ifdef RPSC_SEQ_AUTORESTART_EN
                    clr_retry  = 1'b1;
                end else if (code_q != FC_ALARM && !retry_q) begin
                    next_state = ST_SHUTDOWN;
                    set_retry  = 1'b1;
`endif
                end
            end
            default: next_state = ST_IDLE;
        endcase

        if (go_fault) begin
            next_state = ST_FAULT;
            if (code_q == FC_NONE) next_code = cause;
        end
`ifdef RPSC_SEQ_AUTORESTART_EN
        // A successful retry ends the attempt, so the cause kept across it is released too.
        if (next_state == ST_RUN && state != ST_RUN) begin
            clr_retry = 1'b1;
            next_code = FC_NONE;
        end
`endif
    end

    // Outputs are decoded from next_state so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            code_q    <= FC_NONE;
            cnt       <= '0;
            fan_act   <= 1'b0;
            ca_ps_act <= 1'b0;
            running   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= next_state;
            code_q    <= next_code;
            fan_act   <= (next_state != ST_IDLE);
            ca_ps_act <= (next_state == ST_CA_WAIT_OK) || (next_state == ST_RUN);
            running   <= (next_state == ST_RUN);
            fault     <= (next_state == ST_FAULT);
            if (next_state != state) cnt <= '0;
            else if (cnt != '1)      cnt <= cnt + 1'b1;
        end
    end

`ifdef RPSC_SEQ_AUTORESTART_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         retry_q <= 1'b0;
        else if (clr_retry) retry_q <= 1'b0;
        else if (set_retry) retry_q <= 1'b1;
    end
`endif

    assign fault_code = code_q;
    assign state_o    = state;

endmodule

// File: tb/tb_rpsc_startup_sequencer.sv
// Directed self-checking bench for rpsc_startup_sequencer in test_mode (short dwells).
module tb_rpsc_startup_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, stop, fault_ack;
    logic       not_alarm, fan_on_perm_n, ca_on_perm_n, not_ca_ok;
    logic       fan_act, ca_ps_act, running, fault;
    logic [2:0] fault_code, state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rpsc_startup_sequencer #(.test_mode(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .fault_ack     (fault_ack),
        .not_alarm     (not_alarm),
        .fan_on_perm_n (fan_on_perm_n),
        .ca_on_perm_n  (ca_on_perm_n),
        .not_ca_ok     (not_ca_ok),
        .fan_act       (fan_act),
        .ca_ps_act     (ca_ps_act),
        .running       (running),
        .fault         (fault),
        .fault_code    (fault_code),
        .state_o       (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_and_rundown();
        fault_ack = 1'b1;
        step(1);
        fault_ack = 1'b0;
        check("ack_to_shutdown", state_o, 5);
        check("ack_clears_code", fault_code, 0);
        step(8);
        check("rundown_to_idle", state_o, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; fault_ack = 1'b0;
        not_alarm = 1'b1; fan_on_perm_n = 1'b1; ca_on_perm_n = 1'b1; not_ca_ok = 1'b1;
        step(2);
        check("rst_state", state_o, 0);
        check("rst_outs", {fan_act, ca_ps_act, running, fault}, 4'b0000);
        check("rst_code", fault_code, 0);

        reset = 1'b1; fan_on_perm_n = 1'b0; ca_on_perm_n = 1'b0;
        step(3);

        // Nominal startup
        start = 1'b1;
        step(1);
        check("nom_fan_rise", fan_act, 1);
        check("nom_spinup", state_o, 1);
        step(7);
        check("nom_spinup_last", state_o, 1);
        step(1);
        check("nom_wait_perm", state_o, 2);
        check("nom_ca_low", ca_ps_act, 0);
        step(1);
        check("nom_wait_ok", state_o, 3);
        check("nom_ca_rise", ca_ps_act, 1);
        not_ca_ok = 1'b0;
        step(2);
        check("nom_run_not_yet", running, 0);
        step(1);
        check("nom_running", running, 1);
        check("nom_run_state", state_o, 4);
        check("nom_code", fault_code, 0);
        stop = 1'b1; start = 1'b0;
        step(1);
        stop = 1'b0;
        check("stop_shutdown", state_o, 5);
        check("stop_outs", {fan_act, ca_ps_act, running}, 3'b100);
        step(7);
        check("rundown_fan_on", fan_act, 1);
        step(1);
        check("rundown_idle", state_o, 0);
        check("rundown_fan_off", fan_act, 0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        step(2);
        check("start_stop_idle", state_o, 0);
        check("start_stop_fan", fan_act, 0);
        start = 1'b0; stop = 1'b0;

        // Fan failure
        fan_on_perm_n = 1'b1; not_ca_ok = 1'b1;
        step(3);
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("fanfail_ca_low", ca_ps_act, 0);
        end
        check("fanfail_spinup", state_o, 1);
        step(1);
        start = 1'b0;
        check("fanfail_state", state_o, 6);
        check("fanfail_code", fault_code, 2);
        check("fanfail_outs", {fan_act, ca_ps_act, fault}, 3'b101);
        ack_and_rundown();

        // CA-OK timeout
        fan_on_perm_n = 1'b0;
        step(3);
        start = 1'b1;
        step(10);
        check("cato_wait_ok", state_o, 3);
        step(39);
        check("cato_last", state_o, 3);
        check("cato_ca_on", ca_ps_act, 1);
        step(1);
        start = 1'b0;
        check("cato_state", state_o, 6);
        check("cato_code", fault_code, 4);
        check("cato_ca_drop", ca_ps_act, 0);
        check("cato_fan", fan_act, 1);
        ack_and_rundown();

        // Alarm in RUN
        not_ca_ok = 1'b0;
        step(3);
        start = 1'b1;
        step(11);
        check("alarm_pre_run", running, 1);
        not_alarm = 1'b0;
        step(2);
        check("alarm_not_yet", ca_ps_act, 1);
        step(1);
        start = 1'b0;
        check("alarm_state", state_o, 6);
        check("alarm_code", fault_code, 1);
        check("alarm_ca_drop", ca_ps_act, 0);
        fault_ack = 1'b1;
        step(2);
        fault_ack = 1'b0;
        check("alarm_ack_ignored", state_o, 6);
        check("alarm_code_held", fault_code, 1);
        not_alarm = 1'b1;
        step(3);
        check("alarm_clear_waits", state_o, 6);
        fault_ack = 1'b1;
        step(1);
        fault_ack = 1'b0;
        check("alarm_ack_shutdown", state_o, 5);
        step(7);
        check("alarm_rundown_fan", fan_act, 1);
        step(1);
        check("alarm_idle", state_o, 0);
        check("alarm_idle_fan", fan_act, 0);

        // CA lost in RUN, then a later alarm must not overwrite the latched cause
        start = 1'b1;
        step(11);
        check("lost_run", state_o, 4);
        ca_on_perm_n = 1'b1;
        step(3);
        check("lost_state", state_o, 6);
        check("lost_code", fault_code, 5);
        not_alarm = 1'b0;
        step(4);
        check("first_cause_kept", fault_code, 5);
        not_alarm = 1'b1; start = 1'b0; ca_on_perm_n = 1'b0;
        step(3);
        ack_and_rundown();

        // start while alarmed in IDLE
        not_alarm = 1'b0;
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("idle_alarm_state", state_o, 6);
        check("idle_alarm_code", fault_code, 1);
        not_alarm = 1'b1;
        step(3);
        ack_and_rundown();

        // stop in CA_WAIT_OK with not_ca_ok falling at the same time
        not_ca_ok = 1'b1;
        step(3);
        start = 1'b1;
        step(10);
        check("late_ok_wait", state_o, 3);
        not_ca_ok = 1'b0; stop = 1'b1;
        step(1);
        check("late_ok_shutdown", state_o, 5);
        check("late_ok_ca_drop", ca_ps_act, 0);
        start = 1'b0; stop = 1'b0;
        step(3);
        check("late_ok_no_run", running, 0);
        step(5);
        check("late_ok_idle", state_o, 0);

        // Reset pulse in RUN
        start = 1'b1;
        step(11);
        check("rstpulse_run", state_o, 4);
        #2;
        reset = 1'b0;
        #1;
        check("rstpulse_async_outs", {fan_act, ca_ps_act, running, fault}, 4'b0000);
        check("rstpulse_async_state", state_o, 0);
        start = 1'b0;
        #2;
        reset = 1'b1;
        step(1);
        check("rstpulse_idle", state_o, 0);
        check("rstpulse_fan", fan_act, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
